// File: rtl/bind_kernel_pkg.sv
// rtl/bind_kernel_pkg.sv - shared state and mode encodings for the bind kernel
package bind_kernel_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PERM  = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } BindKernel_State_t;

    localparam logic BIND_XOR  = 1'b0;
    localparam logic BIND_PERM = 1'b1;

endpackage

// File: rtl/hv_rotate.sv
// rtl/hv_rotate.sv - combinational variable rotate-left of a hypervector word
module hv_rotate #(
    parameter int HV_DATA_WIDTH = 32,
    parameter int SHIFT_W       = 5
) (
    input  logic [HV_DATA_WIDTH-1:0] data,
    input  logic [SHIFT_W-1:0]       amount,
    output logic [HV_DATA_WIDTH-1:0] result
);

    // Shifting the doubled word left and keeping the upper half yields the rotation.
    assign result = HV_DATA_WIDTH'({data, data} << amount >> HV_DATA_WIDTH);

endmodule

// File: rtl/bind_kernel.sv
// rtl/bind_kernel.sv - bind kernel: optional per-operand rotate then XOR-accumulate
module bind_kernel
    import bind_kernel_pkg::*;
#(
    parameter int HV_DATA_WIDTH = 32,
    parameter int MAX_OPERANDS  = 8,
    parameter int PERM_SHIFT    = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid,
    input  logic                     first,
    input  logic                     last,
    input  logic                     mode,
    input  logic [HV_DATA_WIDTH-1:0] data_in,
    output logic [HV_DATA_WIDTH-1:0] data_out,
    output logic                     ready,
    output logic                     done,
    output logic                     err
);

    localparam int IDX_W   = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;
    localparam int SHIFT_W = (HV_DATA_WIDTH > 1) ? $clog2(HV_DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_OPERANDS - 1);

    BindKernel_State_t        state;
    logic [HV_DATA_WIDTH-1:0] word_q;
    logic [HV_DATA_WIDTH-1:0] acc;
    logic [HV_DATA_WIDTH-1:0] rot;
    logic [HV_DATA_WIDTH-1:0] acc_next;
    logic [IDX_W-1:0]         idx;
    logic [SHIFT_W-1:0]       rot_amt;
    logic                     mode_q;
    logic                     last_q;
    logic                     accept;

    assign ready  = (state != S_PERM);
    assign done   = (state == S_DONE);
    assign accept = valid & ready;

    assign rot_amt = (mode_q == BIND_PERM)
                   ? SHIFT_W'((32'(idx) * 32'(PERM_SHIFT)) % 32'(HV_DATA_WIDTH))
                   : '0;

    hv_rotate #(
        .HV_DATA_WIDTH (HV_DATA_WIDTH),
        .SHIFT_W       (SHIFT_W)
    ) u_rotate (
        .data   (word_q),
        .amount (rot_amt),
        .result (rot)
    );

    // Operand 0 seeds the accumulator so a restarted sequence never sees stale acc.
    assign acc_next = (idx == '0) ? rot : (acc ^ rot);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            word_q   <= '0;
            acc      <= '0;
            data_out <= '0;
            idx      <= '0;
            mode_q   <= 1'b0;
            last_q   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_PERM: begin
                    acc <= acc_next;
                    if (last_q) begin
                        data_out <= acc_next;
                        state    <= S_DONE;
                    end else begin
                        state <= S_ACCUM;
                    end
                end
                default: begin
                    if (accept) begin
                        if (first) begin
                            mode_q <= mode;
                            word_q <= data_in;
                            last_q <= last;
                            idx    <= '0;
                            state  <= S_PERM;
                            if (state == S_ACCUM) err <= 1'b1;
                        end else if (state == S_ACCUM) begin
                            word_q <= data_in;
                            last_q <= last;
                            if (idx != IDX_MAX) idx <= idx + IDX_W'(1);
                            state  <= S_PERM;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
